reverse_stream_unit: RTL and testbench

Parametrised, registered data-reordering stage with a streaming valid/ready interface. Per-word mode selects one of four reorderings: pass-through, full bit reverse, byte swap (endian) or halfword swap. Results are held in a 2-entry output buffer, so the upstream sees full throughput under backpressure. It sits in the datapath between the operand source and the consumer, and keeps a count of completed transfers.

---
 rtl/reverse_stream_unit_pkg.sv | 20 ++
 rtl/reverse_stream_unit_bit_permute_core.sv | 48 ++++
 rtl/reverse_stream_unit.sv | 94 +++++++++
 tb/tb_reverse_stream_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reverse_stream_unit_pkg.sv
// Shared types for the reverse stream unit: per-word reorder modes and
// the output buffer occupancy states.
package reverse_stream_unit_pkg;

    // Reordering applied to a word as it enters the unit
    typedef enum logic [1:0] {
        MODE_PASS     = 2'b00,
        MODE_BITREV   = 2'b01,
        MODE_BYTESWAP = 2'b10,
        MODE_HWSWAP   = 2'b11
    } mode_e;

    // Occupancy of the 2-entry output buffer
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_e;

endpackage

// File: rtl/reverse_stream_unit_bit_permute_core.sv
// Purely combinational word reordering: pass, bit reverse, byte swap or
// halfword swap. WIDTH must be a multiple of 16.
module bit_permute_core
    import reverse_stream_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] out
);

    localparam int NBYTES = WIDTH / 8;
    localparam int NHALFS = WIDTH / 16;

    logic [WIDTH-1:0] bitrev;
    logic [WIDTH-1:0] byteswap;
    logic [WIDTH-1:0] hwswap;

    // Bit i takes bit WIDTH-1-i
    for (genvar i = 0; i < WIDTH; i++) begin : g_bitrev
        assign bitrev[i] = in[WIDTH-1-i];
    end

    // Byte k moves to byte NBYTES-1-k
    for (genvar k = 0; k < NBYTES; k++) begin : g_byteswap
        assign byteswap[8*k +: 8] = in[8*(NBYTES-1-k) +: 8];
    end

    // Halfword k moves to halfword NHALFS-1-k
    for (genvar k = 0; k < NHALFS; k++) begin : g_hwswap
        assign hwswap[16*k +: 16] = in[16*(NHALFS-1-k) +: 16];
    end

    // Select the reordering requested for this word
    always_comb begin
        // NOTE: out gets a default before the case so no path leaves it unassigned (no latch).
        out = in;
        case (mode)
            MODE_PASS:     out = in;
            MODE_BITREV:   out = bitrev;
            MODE_BYTESWAP: out = byteswap;
            MODE_HWSWAP:   out = hwswap;
            default:       out = in;
        endcase
    end

endmodule

// File: rtl/reverse_stream_unit.sv
// Registered reordering stage with valid/ready handshakes on both sides,
// a 2-entry output buffer for full throughput under backpressure, and a
// wrapping count of completed output transfers.
module reverse_stream_unit
    import reverse_stream_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] xfer_count
);

    state_e           state;
    state_e           state_nxt;
    logic [WIDTH-1:0] head_q;   // oldest entry, always presented on out_data
    logic [WIDTH-1:0] tail_q;   // second entry, valid only in ST_FULL
    logic [WIDTH-1:0] xform;
    logic [CNT_W-1:0] cnt_q;
    logic             push;
    logic             pop;

    bit_permute_core #(
        .WIDTH (WIDTH)
    ) u_permute (
        .in   (in_data),
        .mode (in_mode),
        .out  (xform)
    );

    // Handshake flags come from registered state only, so in_ready has no
    // combinational path from out_ready.
    assign in_ready   = (state != ST_FULL);
    assign out_valid  = (state != ST_EMPTY);
    assign push       = in_valid & in_ready;
    assign pop        = out_valid & out_ready;
    assign out_data   = head_q;
    assign xfer_count = cnt_q;

    // Occupancy next-state from push/pop
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (push) state_nxt = ST_ONE;
            ST_ONE: begin
                if (push && !pop)      state_nxt = ST_FULL;
                else if (pop && !push) state_nxt = ST_EMPTY;
            end
            ST_FULL:  if (pop) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // Occupancy state register
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses <= so every register samples pre-edge values.
        if (rst) state <= ST_EMPTY;
        else     state <= state_nxt;
    end

    // Buffer entries: fill head first, spill to tail, shift tail up on pop
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the entries are reset because out_data must read zero after reset.
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            case (state)
                ST_EMPTY: if (push) head_q <= xform;
                ST_ONE: begin
                    if (push && pop) head_q <= xform;
                    else if (push)   tail_q <= xform;
                end
                ST_FULL:  if (pop) head_q <= tail_q;
                default: ;
            endcase
        end
    end

    // Completed-transfer counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      cnt_q <= '0;
        else if (pop) cnt_q <= cnt_q + 1'b1;
    end

endmodule

// File: tb/tb_reverse_stream_unit.sv
// Scoreboard bench for reverse_stream_unit: pushes record the expected
// reordered word, pops compare against the queue head in order.
module tb_reverse_stream_unit;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_mode;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] xfer_count;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] sb[$];
    logic [CNT_W-1:0] exp_cnt;

    reverse_stream_unit #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_mode    (in_mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    // Reference reordering built from streaming operators
    function automatic logic [WIDTH-1:0] ref_xform(input logic [WIDTH-1:0] d,
                                                   input logic [1:0] m);
        logic [WIDTH-1:0] r;
        case (m)
            2'b00:   r = d;
            2'b01:   r = {<<{d}};
            2'b10:   r = {<<8{d}};
            default: r = {<<16{d}};
        endcase
        return r;
    endfunction

    // One clock: sample at negedge, score pop/push, leave inputs 1 after posedge
    task automatic step();
        logic did_pop;
        logic [WIDTH-1:0] exp;
        @(negedge clk);
        did_pop = 1'b0;
        checks++;
        if (out_valid !== (sb.size() != 0)) begin
            failures++;
            $display("FAIL occupancy_out_valid got=%b want=%b", out_valid, sb.size() != 0);
        end
        checks++;
        if (in_ready !== (sb.size() < 2)) begin
            failures++;
            $display("FAIL occupancy_in_ready got=%b want=%b", in_ready, sb.size() < 2);
        end
        checks++;
        if (xfer_count !== exp_cnt) begin
            failures++;
            $display("FAIL xfer_count got=%0d want=%0d", xfer_count, exp_cnt);
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            did_pop = 1'b1;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output got=%h want=none", out_data);
            end else begin
                exp = sb.pop_front();
                if (out_data !== exp) begin
                    failures++;
                    $display("FAIL out_data got=%h want=%h", out_data, exp);
                end
            end
        end
        if (in_valid === 1'b1 && in_ready === 1'b1)
            sb.push_back(ref_xform(in_data, in_mode));
        if (did_pop) exp_cnt = exp_cnt + 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Drain remaining words with a bounded cycle budget
    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8 && sb.size() != 0; i++) step();
        step();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout got=%0d_left want=0_left", sb.size());
        end
    endtask

    task automatic apply_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        in_mode   = 2'b00;
        rst       = 1'b1;
        #3;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || xfer_count !== '0 || out_data !== '0) begin
            failures++;
            $display("FAIL reset_state got=v%b r%b c%0d d%h want=v0 r1 c0 d0",
                     out_valid, in_ready, xfer_count, out_data);
        end
        sb.delete();
        exp_cnt = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        step();
    endtask

    task automatic test_bitrev();
        out_ready = 1'b1;
        in_data   = 32'h0000_0001;
        in_mode   = 2'b01;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h8000_0000) begin
            failures++;
            $display("FAIL bitrev_latency got=v%b d%h want=v1 d80000000", out_valid, out_data);
        end
        step();
        step();
        checks++;
        if (xfer_count !== 4'd1) begin
            failures++;
            $display("FAIL bitrev_count got=%0d want=1", xfer_count);
        end
    endtask

    task automatic test_swaps();
        logic [WIDTH-1:0] want[3];
        logic [1:0]       modes[3];
        want[0] = 32'h7856_3412; modes[0] = 2'b10;
        want[1] = 32'h5678_1234; modes[1] = 2'b11;
        want[2] = 32'h1234_5678; modes[2] = 2'b00;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            in_mode = modes[i];
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== want[i]) begin
                failures++;
                $display("FAIL swap_%0d got=v%b d%h want=v1 d%h", i, out_valid, out_data, want[i]);
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [CNT_W-1:0] want_cnt;
        want_cnt  = exp_cnt + 4'd3;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'b00;
        in_data   = 32'hA;
        step();
        in_data = 32'hB;
        step();
        in_data = 32'hC;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_full_ready got=%b want=0", in_ready);
        end
        step();
        step();
        out_ready = 1'b1;
        step();
        step();
        drain();
        checks++;
        if (xfer_count !== want_cnt) begin
            failures++;
            $display("FAIL bp_count got=%0d want=%0d", xfer_count, want_cnt);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = $urandom;
            in_mode = 2'($urandom_range(0, 3));
            step();
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready_%0d got=%b want=1", i, in_ready);
            end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'b10;
        in_data   = 32'hDEAD_BEEF;
        step();
        in_data = 32'hCAFE_F00D;
        step();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || xfer_count !== '0 || out_data !== '0) begin
            failures++;
            $display("FAIL midreset_state got=v%b r%b c%0d d%h want=v0 r1 c0 d0",
                     out_valid, in_ready, xfer_count, out_data);
        end
        sb.delete();
        exp_cnt = '0;
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mode   = 2'b11;
        in_data   = 32'hAAAA_5555;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h5555_AAAA) begin
            failures++;
            $display("FAIL midreset_first got=v%b d%h want=v1 d5555aaaa", out_valid, out_data);
        end
        drain();
    endtask

    task automatic test_wrap();
        apply_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_data = WIDTH'(i * 32'h0101_0101 + 32'h10);
            in_mode = 2'(i);
            step();
        end
        drain();
        checks++;
        if (xfer_count !== 4'd1) begin
            failures++;
            $display("FAIL wrap_count got=%0d want=1", xfer_count);
        end
    endtask

    initial begin
        exp_cnt = '0;
        test_reset();
        test_bitrev();
        test_swaps();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
